// File: rtl/spi_pkg.sv
// Shared types for the SPI transfer front-end: req mode codes, controller FSM states,
// and the default transfer width.
package spi_pkg;

  localparam int SPI_TRF_BIT_DEF = 8;

  typedef enum logic [1:0] {
    REQ_NONE   = 2'b00,
    REQ_MOSI   = 2'b01,
    REQ_MISO   = 2'b10,
    REQ_DUPLEX = 2'b11
  } req_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_STORE,
    ST_GAP
  } state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/level; the head is readable with zero latency.
// Push is refused whenever full, even if a pop coincides; DEPTH must be a power of 2 (min 2).
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  // Head is forced to zero while empty so stale storage never shows on the output.
  assign dout   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Host command front-end for spi_top: queues {mode,byte}, runs one req transfer at a time, queues RX bytes.
// Optional watchdog under macro SPI_XFER_TIMEOUT_EN sets sticky err and aborts a hung transfer.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int SPI_TRF_BIT    = SPI_TRF_BIT_DEF,
  parameter int CMD_DEPTH      = 4,
  parameter int RX_DEPTH       = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int WAIT_DURATION  = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_mode,
  input  logic [SPI_TRF_BIT-1:0] cmd_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [SPI_TRF_BIT-1:0] rx_data,
  output logic [1:0]             req,
  output logic [SPI_TRF_BIT-1:0] din_master,
  output logic [7:0]             wait_duration,
  input  logic [SPI_TRF_BIT-1:0] dout_master,
  input  logic                   done_tx,
  input  logic                   done_rx,
  input  logic                   spi_idle,
  output logic                   busy,
  output logic                   err
);

  localparam int CW = SPI_TRF_BIT + 2;
  localparam int GW = $clog2(GAP_CYCLES + 2);

  logic                         w_cmd_full, w_cmd_empty, w_cmd_pop;
  logic [CW-1:0]                w_cmd_head;
  logic [$clog2(CMD_DEPTH):0]   w_cmd_level;
  logic                         w_rx_full, w_rx_empty, w_rx_push, w_rx_space;
  logic [$clog2(RX_DEPTH):0]    w_rx_level;
  req_e                         w_head_mode;
  logic [SPI_TRF_BIT-1:0]       w_head_data;

  state_e                       r_state, w_state_nxt;
  req_e                         r_req;
  logic [SPI_TRF_BIT-1:0]       r_din;
  logic [SPI_TRF_BIT-1:0]       r_rx_byte;
  logic                         r_done_tx_q, r_done_rx_q;
  logic                         r_tx_seen, r_rx_seen;
  logic [GW-1:0]                r_gap_cnt;
  logic                         w_tx_rise, w_rx_rise, w_tx_ok, w_rx_ok;
  logic                         w_done_ok, w_gap_last, w_to_hit;
  logic                         w_launch, w_complete, w_abort;

  spi_sync_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   ({cmd_mode, cmd_data}),
    .pop   (w_cmd_pop),
    .dout  (w_cmd_head),
    .full  (w_cmd_full),
    .empty (w_cmd_empty),
    .level (w_cmd_level)
  );

  spi_sync_fifo #(.WIDTH(SPI_TRF_BIT), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .din   (r_rx_byte),
    .pop   (rx_ready),
    .dout  (rx_data),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .level (w_rx_level)
  );

  assign w_head_mode   = req_e'(w_cmd_head[CW-1 -: 2]);
  assign w_head_data   = w_cmd_head[SPI_TRF_BIT-1:0];
  assign cmd_ready     = ~w_cmd_full;
  assign rx_valid      = ~w_rx_empty;
  assign req           = r_req;
  assign din_master    = r_din;
  assign wait_duration = 8'(WAIT_DURATION);
  assign busy          = (r_state != ST_IDLE) || (w_cmd_level != '0);

  // Only one transfer is ever in flight, so in IDLE no STORE push is pending against this level.
  assign w_rx_space = (int'(w_rx_level) < RX_DEPTH);
  assign w_rx_push  = (r_state == ST_STORE) && ~w_rx_full;

  assign w_tx_rise  = done_tx & ~r_done_tx_q;
  assign w_rx_rise  = done_rx & ~r_done_rx_q;
  assign w_tx_ok    = r_tx_seen | w_tx_rise;
  assign w_rx_ok    = r_rx_seen | w_rx_rise;
  assign w_gap_last = (int'(r_gap_cnt) + 1 >= GAP_CYCLES);

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_pop   = 1'b0;
    w_launch    = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    w_done_ok   = 1'b0;
    case (r_req)
      REQ_MOSI:   w_done_ok = w_tx_ok;
      REQ_MISO:   w_done_ok = w_rx_ok;
      REQ_DUPLEX: w_done_ok = w_tx_ok & w_rx_ok;
      default:    w_done_ok = 1'b0;
    endcase
    case (r_state)
      ST_IDLE: begin
        if (!w_cmd_empty && spi_idle) begin
          if (w_head_mode == REQ_NONE) begin
            w_cmd_pop = 1'b1;
          end else if (!w_head_mode[1] || w_rx_space) begin
            w_cmd_pop   = 1'b1;
            w_launch    = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (w_done_ok) begin
          w_complete  = 1'b1;
          w_state_nxt = r_req[1] ? ST_STORE : ST_GAP;
        end else if (w_to_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_STORE: w_state_nxt = ST_GAP;
      ST_GAP:   if (w_gap_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_req       <= REQ_NONE;
      r_din       <= '0;
      r_rx_byte   <= '0;
      r_done_tx_q <= 1'b0;
      r_done_rx_q <= 1'b0;
      r_tx_seen   <= 1'b0;
      r_rx_seen   <= 1'b0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_done_tx_q <= done_tx;
      r_done_rx_q <= done_rx;
      if (w_launch) begin
        r_req <= w_head_mode;
        r_din <= (w_head_mode == REQ_MISO) ? '0 : w_head_data;
      end else if (w_complete || w_abort) begin
        r_req <= REQ_NONE;
      end
      if (w_complete) r_rx_byte <= dout_master;
      // Done edges only count while a transfer is outstanding.
      if (r_state == ST_BUSY) begin
        if (w_tx_rise) r_tx_seen <= 1'b1;
        if (w_rx_rise) r_rx_seen <= 1'b1;
      end else begin
        r_tx_seen <= 1'b0;
        r_rx_seen <= 1'b0;
      end
      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GW'(1) : '0;
    end
  end

`ifdef SPI_XFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == ST_BUSY) ? r_to_cnt + TW'(1) : '0;
      if (w_abort) r_err <= 1'b1;
    end
  end

  assign w_to_hit = (r_state == ST_BUSY) && (int'(r_to_cnt) == TIMEOUT_CYCLES - 1);
  assign err      = r_err;
`else
  assign w_to_hit = 1'b0;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Randomized scoreboard bench for spi_xfer_ctrl with a behavioural spi_top responder model.
module tb_spi_xfer_ctrl;

  localparam int W             = 8;
  localparam int CMD_DEPTH     = 4;
  localparam int RX_DEPTH      = 4;
  localparam int GAP_CYCLES    = 4;
  localparam int WAIT_DURATION = 10;

  logic         clk, rst;
  logic         cmd_valid, cmd_ready, rx_valid, rx_ready;
  logic [1:0]   cmd_mode, req;
  logic [W-1:0] cmd_data, rx_data, din_master, dout_master;
  logic [7:0]   wait_duration;
  logic         done_tx, done_rx, spi_idle, busy, err;

  int         checks   = 0;
  int         failures = 0;
  logic [9:0] exp_req_q[$];
  logic [7:0] exp_rx_q[$];
  int         launches    = 0;
  bit         active      = 0;
  bit         idle_hold   = 0;
  bit         stray_en    = 0;
  bit         force_dly   = 0;
  int         f_tx        = 1;
  int         f_rx        = 1;
  int         rx_pop_mode = 2;
  int         pop_grant   = 0;

  spi_xfer_ctrl #(
    .SPI_TRF_BIT   (W),
    .CMD_DEPTH     (CMD_DEPTH),
    .RX_DEPTH      (RX_DEPTH),
    .GAP_CYCLES    (GAP_CYCLES),
    .WAIT_DURATION (WAIT_DURATION)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mode      (cmd_mode),
    .cmd_data      (cmd_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .req           (req),
    .din_master    (din_master),
    .wait_duration (wait_duration),
    .dout_master   (dout_master),
    .done_tx       (done_tx),
    .done_rx       (done_rx),
    .spi_idle      (spi_idle),
    .busy          (busy),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: got %s (t=%0t)", name, what, $time);
  endtask

  // Responder: acts like spi_top, pulsing done lines after random delays per launched transfer.
  initial begin : spi_model
    logic [1:0] cur_mode;
    logic [7:0] cur_din;
    logic [9:0] e;
    int         cnt, tx_at, rx_at, last_at;
    bit         fin;
    done_tx = 0; done_rx = 0; dout_master = '0; spi_idle = 1;
    cur_mode = 0; cur_din = 0; cnt = 0; tx_at = 0; rx_at = 0; last_at = 0; fin = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 0; fin = 0; done_tx = 0; done_rx = 0;
      end else begin
        done_tx = 0;
        done_rx = 0;
        if (!active) begin
          if (req != 2'b00) begin
            launches++;
            active   = 1;
            fin      = 0;
            cnt      = 0;
            cur_mode = req;
            cur_din  = din_master;
            if (exp_req_q.size() == 0) begin
              fail("unexpected_launch", $sformatf("req=%0b with no queued command, expected none", req));
            end else begin
              e = exp_req_q.pop_front();
              chk("launch_mode", 32'(req), 32'(e[9:8]));
              chk("launch_din", 32'(din_master), 32'(e[7:0]));
            end
            tx_at   = force_dly ? f_tx : $urandom_range(1, 8);
            rx_at   = force_dly ? f_rx : $urandom_range(1, 8);
            last_at = 0;
            if (cur_mode[0]) last_at = tx_at;
            if (cur_mode[1] && rx_at > last_at) last_at = rx_at;
            if (cur_mode[1]) begin
              dout_master = 8'($urandom);
              exp_rx_q.push_back(dout_master);
            end
          end else if (stray_en && $urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 1) done_tx = 1;
            else done_rx = 1;
          end
        end else if (fin) begin
          chk("req_drop", 32'(req), 32'd0);
          active = 0;
        end else begin
          chk("req_hold", {22'd0, req, din_master}, {22'd0, cur_mode, cur_din});
          cnt++;
          if (cur_mode[0] && cnt == tx_at) done_tx = 1;
          if (cur_mode[1] && cnt == rx_at) done_rx = 1;
          if (cnt == last_at) fin = 1;
        end
      end
      spi_idle = !active && !idle_hold;
    end
  end

  // RX monitor: owns rx_ready, pops and compares against bytes the responder sent.
  initial begin : rx_mon
    logic [7:0] e;
    int used;
    used = 0;
    rx_ready = 0;
    forever begin
      @(negedge clk);
      case (rx_pop_mode)
        0: rx_ready = 0;
        1: rx_ready = 1'($urandom_range(0, 1));
        2: rx_ready = 1;
        default: begin
          rx_ready = rx_valid && (used < pop_grant);
          if (rx_ready) used++;
        end
      endcase
      if (rst && rx_valid && rx_ready) begin
        if (exp_rx_q.size() == 0) begin
          fail("unexpected_rx", $sformatf("rx byte 0x%0h, expected none", rx_data));
        end else begin
          e = exp_rx_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e));
        end
      end
    end
  end

  // Idle spacing between consecutive req assertions.
  initial begin : gap_mon
    int zeros;
    bit seen;
    logic [1:0] prev;
    zeros = 0; seen = 0; prev = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        zeros = 0; seen = 0; prev = 0;
      end else begin
        if (req == 2'b00) begin
          zeros++;
        end else begin
          if (prev == 2'b00 && seen) begin
            checks++;
            if (zeros < GAP_CYCLES) begin
              failures++;
              $display("FAIL req_gap: got %0d idle cycles, expected >= %0d (t=%0t)", zeros, GAP_CYCLES, $time);
            end
          end
          seen  = 1;
          zeros = 0;
        end
        prev = req;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] m, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_mode = m; cmd_data = d;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail("cmd_accept", "cmd_ready stuck low, expected acceptance");
      cmd_valid = 0;
      return;
    end
    if (m != 2'b00) exp_req_q.push_back({m, (m == 2'b10) ? 8'h00 : d});
    @(posedge clk);
    #1;
    cmd_valid = 0;
    cmd_data  = 8'($urandom);
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while (n < 3000 && !(exp_req_q.size() == 0 && exp_rx_q.size() == 0 && !active && !busy && req == 2'b00)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail(name, $sformatf("busy=%0b req=%0b pending=%0d/%0d, expected drained", busy, req, exp_req_q.size(), exp_rx_q.size()));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(req), 32'd0);
    chk({tag, "_din"}, 32'(din_master), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin : main
    int l0, n;
    rst = 0; cmd_valid = 0; cmd_mode = 0; cmd_data = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    chk("wait_duration", 32'(wait_duration), 32'(WAIT_DURATION));
    @(posedge clk); #1 rst = 1;

    // Single MOSI, including launch latency from an empty FIFO.
    send_cmd(2'b01, 8'hA5);
    repeat (2) @(negedge clk);
    chk("t1_req_latency", 32'(req), 32'h1);
    chk("t1_din", 32'(din_master), 32'hA5);
    wait_quiet("t1_quiet");
    chk("t1_no_rx", 32'(rx_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // Single MISO.
    send_cmd(2'b10, 8'h77);
    wait_quiet("t2_quiet");
    chk("t2_rx_drained", 32'(rx_valid), 32'd0);

    // Duplex with done_rx five cycles ahead of done_tx.
    force_dly = 1; f_rx = 1; f_tx = 6;
    send_cmd(2'b11, 8'h5A);
    wait_quiet("t3_quiet");
    force_dly = 0;
    chk("t3_one_rx", 32'(rx_valid), 32'd0);

    // RX backpressure: five reads into a four-deep RX FIFO.
    rx_pop_mode = 3;
    l0 = launches;
    repeat (5) send_cmd(2'b10, 8'($urandom));
    repeat (150) @(negedge clk);
    chk("t4_held_launches", 32'(launches - l0), 32'd4);
    chk("t4_rx_valid", 32'(rx_valid), 32'd1);
    chk("t4_req_idle", 32'(req), 32'd0);
    pop_grant++;
    n = 0;
    while (launches - l0 < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_fifth_launch", 32'(launches - l0), 32'd5);
    rx_pop_mode = 2;
    wait_quiet("t4_quiet");

    // spi_idle gating with a no-op command between two transfers.
    idle_hold = 1;
    repeat (2) @(negedge clk);
    l0 = launches;
    send_cmd(2'b01, 8'h11);
    send_cmd(2'b00, 8'h22);
    send_cmd(2'b10, 8'h33);
    repeat (20) @(negedge clk);
    chk("t5_gated_launches", 32'(launches - l0), 32'd0);
    chk("t5_gated_req", 32'(req), 32'd0);
    chk("t5_busy_queued", 32'(busy), 32'd1);
    @(posedge clk); #1 idle_hold = 0;
    wait_quiet("t5_quiet");
    chk("t5_launches", 32'(launches - l0), 32'd2);

    // Reset during BUSY with a second command still queued.
    force_dly = 1; f_tx = 40;
    send_cmd(2'b01, 8'hC3);
    send_cmd(2'b01, 8'h3C);
    n = 0;
    while (!active && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!active) fail("t6_launch", "no launch, expected transfer in progress");
    repeat (3) @(posedge clk);
    #1 rst = 0;
    exp_req_q.delete();
    exp_rx_q.delete();
    repeat (3) @(negedge clk);
    check_reset_vals("t6_mid");
    @(posedge clk); #1 rst = 1;
    force_dly = 0;
    l0 = launches;
    repeat (20) @(negedge clk);
    chk("t6_fifo_flushed", 32'(launches - l0), 32'd0);
    chk("t6_busy_after", 32'(busy), 32'd0);
    send_cmd(2'b11, 8'h96);
    wait_quiet("t6_quiet");

    // Randomized traffic with random RX pops and stray done pulses outside transfers.
    rx_pop_mode = 1;
    stray_en = 1;
    for (int i = 0; i < 40; i++) send_cmd(2'($urandom_range(0, 3)), 8'($urandom));
    rx_pop_mode = 2;
    wait_quiet("rand_quiet");
    stray_en = 0;
    chk("final_err", 32'(err), 32'd0);
    chk("final_rx_valid", 32'(rx_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Master-side command front-end sitting directly upstream of spi_top. It buffers host transfer commands (mode plus byte) in a command FIFO and drives spi_top req/din_master one transfer at a time. It waits on done_tx/done_rx and pushes received dout_master bytes into an RX FIFO for the host. It converts spi_top's level-style req interface into valid/ready streams.

Parameters:
SPI_TRF_BIT, 8, transfer width in bits; matches spi_top.
CMD_DEPTH, 4, command FIFO depth; power of 2, minimum 2.
RX_DEPTH, 4, RX FIFO depth; power of 2, minimum 2.
GAP_CYCLES, 4, minimum idle clk cycles between transfers; 0 is legal.
WAIT_DURATION, 10, value driven on wait_duration.
TIMEOUT_CYCLES, 4096, watchdog limit; used only with the optional feature.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset (rst=0 resets).
cmd_valid  in  1  host command valid.
cmd_ready  out  1  command FIFO not full.
cmd_mode  in  2  01 = write (MOSI), 10 = read (MISO), 11 = full duplex, 00 = no-op.
cmd_data  in  SPI_TRF_BIT  byte to send; ignored for mode 10.
rx_valid  out  1  RX FIFO not empty.
rx_ready  in  1  host pops RX byte.
rx_data  out  SPI_TRF_BIT  RX FIFO head; valid when rx_valid=1.
req  out  2  to spi_top req.
din_master  out  SPI_TRF_BIT  to spi_top din_master.
wait_duration  out  8  to spi_top; constant WAIT_DURATION.
dout_master  in  SPI_TRF_BIT  from spi_top.
done_tx  in  1  from spi_top.
done_rx  in  1  from spi_top.
spi_idle  in  1  all spi_top master/slave FSMs idle.
busy  out  1  FSM not in IDLE, or command FIFO not empty.
err  out  1  sticky timeout flag; constant 0 without the optional feature.

Behaviour:
- Reset values: req=00, din_master=0, cmd_ready=1, rx_valid=0, rx_data=0, busy=0, err=0. Both FIFOs are emptied.
- Reset mid-transfer aborts immediately. req returns to 00 and no RX push occurs.
- FIFOs: first-word-fall-through.
  - Push when valid&&ready; pop when valid&&ready.
  - Simultaneous push and pop on a full FIFO is illegal to accept; ready reflects the registered full flag only.
- FSM states: IDLE, BUSY, STORE, GAP.
- IDLE: launch when command FIFO non-empty and spi_idle=1.
  - For mode 10/11, launch also requires RX FIFO not full, counting the entry STORE will push. This prevents overflow.
  - Mode 00: pop and discard; stay in IDLE; no req.
  - Otherwise: pop, register req<=mode and din_master<=data (mode 10 drives 0), go to BUSY.
  - Timing: req is first valid 2 cycles after the host push into an empty FIFO.
- BUSY: req and din_master are held stable.
  - Detect rising edges of done_tx/done_rx (one registered-previous flop each) and latch them into tx_seen/rx_seen.
  - Completion needs tx_seen for 01, rx_seen for 10, both for 11. The two edges may arrive in any order or the same cycle.
  - On completion: req<=00 on the next edge and capture dout_master. Go to STORE if mode[1], else GAP.
- STORE: push the captured byte into the RX FIFO for one cycle (space guaranteed), then GAP.
- GAP: count GAP_CYCLES cycles (GAP_CYCLES=0 → 1 cycle pass-through), then IDLE. tx_seen/rx_seen clear on entry.
- Done edges outside BUSY are ignored.
- Host may push commands and pop RX at any time, including during a transfer.

Optional Feature:
Macro SPI_XFER_TIMEOUT_EN.
- Defined: a counter runs in BUSY. If completion is not reached within TIMEOUT_CYCLES cycles, the FSM sets err=1 (sticky until reset), drives req<=00, skips STORE and goes to GAP.
- Not defined: no counter; BUSY waits indefinitely; err tied to 0.

Decomposition:
- Shared package spi_pkg: typedef enum for mode codes (REQ_NONE=00, REQ_MOSI=01, REQ_MISO=10, REQ_DUPLEX=11), FSM state enum, and default SPI_TRF_BIT.
- One sub-module spi_sync_fifo (parameterised WIDTH and DEPTH, FWFT, full/empty/level), instantiated twice: command FIFO with WIDTH=SPI_TRF_BIT+2, and RX FIFO.

Test Plan:
1. Single MOSI: push mode=01 data=0xA5 → req=01 and din_master=0xA5 two cycles later; pulse done_tx → req=00 next cycle; no RX push; busy=0 after GAP_CYCLES.
2. Single MISO: push mode=10; model drives dout_master=0x3C then pulses done_rx → rx_valid=1 with rx_data=0x3C; rx_ready pop clears rx_valid.
3. Duplex with done_rx 5 cycles before done_tx → req stays 11 until the done_tx edge; rx_data equals dout_master; exactly one RX entry.
4. Backpressure: rx_ready=0, push 5 mode-10 commands with RX_DEPTH=4 → exactly 4 transfers; fifth held until one pop, then launched.
5. Flow gating: spi_idle=0 with 2 commands queued → req stays 00; mode-00 command in between consumed without req; GAP ≥4 idle cycles between consecutive req assertions.
6. Reset mid-BUSY: rst=0 for 3 cycles during mode 01 → req=00, cmd_ready=1, rx_valid=0, FIFOs empty. With SPI_XFER_TIMEOUT_EN and TIMEOUT_CYCLES=16 and no done → err=1 at cycle 16 of BUSY, req=00.
